// File: rtl/window_addr_sequencer.sv
// Emits a sequence of K-slot address windows over a circular SIZE-slot array.
// Each window is presented with a slot list, per-slot offset map and hit mask.
module window_addr_sequencer #(
  parameter int SIZE  = 16,
  parameter int K     = 8,
  parameter int CNT_W = 8,
  localparam int AW   = $clog2(SIZE),
  localparam int KW   = $clog2(K)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW-1:0]       base_in,
  input  logic [AW-1:0]       stride_in,
  input  logic [CNT_W-1:0]    num_win_in,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [AW*K-1:0]     gen_nums,
  output logic [SIZE*KW-1:0]  sel_map,
  output logic [SIZE-1:0]     hit_mask,
  output logic [CNT_W-1:0]    win_idx,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW:0] SIZE_E = (AW+1)'(SIZE);
  localparam logic [AW:0] K_E    = (AW+1)'(K);

  state_t           state, state_nxt;
  logic [AW-1:0]    base, stride;
  logic [CNT_W-1:0] count, idx;
  logic             accept, hs, last;
  logic [AW:0]      slot_off;

  // Both operands are already below SIZE, so one conditional subtract wraps the sum.
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= SIZE_E) sum = sum - SIZE_E;
    return sum[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] mod_reduce(input logic [AW-1:0] x);
    logic [AW:0] v;
    v = {1'b0, x};
    if (v >= SIZE_E) v = v - SIZE_E;
    return v[AW-1:0];
  endfunction

  // Handshake: a window transfers on a rising edge where out_valid & out_ready;
  // out_valid never drops and outputs never change until that transfer.
  assign accept = (state == IDLE) && start && (num_win_in != '0);
  assign hs     = (state == RUN) && out_ready;
  assign last   = (idx == count - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (hs && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base   <= '0;
      stride <= '0;
      count  <= '0;
      idx    <= '0;
    end else if (accept) begin
      base   <= mod_reduce(base_in);
      stride <= mod_reduce(stride_in);
      count  <= num_win_in;
      idx    <= '0;
    end else if (hs && !last) begin
      base <= mod_add(base, stride);
      idx  <= idx + CNT_W'(1);
    end
  end

  // Window decode works from the registered base only; everything is zero outside RUN.
  always_comb begin
    gen_nums = '0;
    sel_map  = '0;
    hit_mask = '0;
    win_idx  = '0;
    slot_off = '0;
    if (state == RUN) begin
      win_idx = idx;
      for (int j = 0; j < K; j++) begin
        gen_nums[j*AW +: AW] = mod_add(base, AW'(j));
      end
      for (int i = 0; i < SIZE; i++) begin
        slot_off = {1'b0, AW'(i)} + SIZE_E - {1'b0, base};
        if (slot_off >= SIZE_E) slot_off = slot_off - SIZE_E;
        if (slot_off < K_E) begin
          hit_mask[i]          = 1'b1;
          sel_map[i*KW +: KW]  = slot_off[KW-1:0];
        end
      end
    end
  end

  assign out_valid = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_window_addr_sequencer.sv
// Randomized and directed bench for window_addr_sequencer; a monitor compares every
// presented window against a queue filled from an arithmetic reference model.
`timescale 1ns/1ps
module tb_window_addr_sequencer;

  localparam int SIZE  = 16;
  localparam int K     = 8;
  localparam int CNT_W = 8;
  localparam int AW    = $clog2(SIZE);
  localparam int KW    = $clog2(K);
  localparam int OW    = CNT_W + SIZE + SIZE*KW + AW*K;
  localparam int EW    = OW + 1;

  logic                clk;
  logic                rst;
  logic                start;
  logic [AW-1:0]       base_in;
  logic [AW-1:0]       stride_in;
  logic [CNT_W-1:0]    num_win_in;
  logic                out_ready;
  logic                out_valid;
  logic [AW*K-1:0]     gen_nums;
  logic [SIZE*KW-1:0]  sel_map;
  logic [SIZE-1:0]     hit_mask;
  logic [CNT_W-1:0]    win_idx;
  logic                busy;
  logic                done;
  logic [1:0]          state_dbg;

  window_addr_sequencer #(.SIZE(SIZE), .K(K), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_in(base_in), .stride_in(stride_in),
    .num_win_in(num_win_in), .out_ready(out_ready), .out_valid(out_valid),
    .gen_nums(gen_nums), .sel_map(sel_map), .hit_mask(hit_mask), .win_idx(win_idx),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: window w starts at (b0 + w*st) mod SIZE; offset j lands on slot (start+j) mod SIZE.
  function automatic logic [EW-1:0] model_window(input int b0, input int st, input int w, input bit last);
    logic [AW*K-1:0]    g;
    logic [SIZE*KW-1:0] s;
    logic [SIZE-1:0]    h;
    int b, v;
    g = '0; s = '0; h = '0;
    b = (b0 + w * st) % SIZE;
    for (int j = 0; j < K; j++) begin
      v = (b + j) % SIZE;
      g[j*AW +: AW] = AW'(v);
      h[v] = 1'b1;
      s[v*KW +: KW] = KW'(j);
    end
    return {last, CNT_W'(w), h, s, g};
  endfunction

  // monitor
  logic [OW-1:0] cur;
  logic [EW-1:0] head;
  bit pend_done = 0;
  bit want_valid = 0;

  always @(negedge clk) begin
    cur = {win_idx, hit_mask, sel_map, gen_nums};
    if (rst) begin
      pend_done  = 0;
      want_valid = 0;
    end else begin
      if (pend_done) begin
        check("done_pulse", EW'({done, busy, out_valid}), EW'(3'b110));
        pend_done = 0;
      end else if (done) begin
        check("spurious_done", EW'(done), EW'(0));
      end
      if (want_valid) begin
        check("no_bubble", EW'(out_valid), EW'(1));
        want_valid = 0;
      end
      if (!out_valid) begin
        check("idle_outputs_zero", EW'(cur), EW'(0));
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got %h required no window", cur);
      end else begin
        head = exp_q[0];
        check("window", EW'(cur), EW'(head[OW-1:0]));
        if (out_ready) begin
          head = exp_q.pop_front();
          pend_done  = head[EW-1];
          want_valid = !head[EW-1];
        end
      end
    end
  end

  // driver tasks (called at posedge+1 with the DUT idle)
  task automatic issue_start(input int b, input int st, input int n);
    base_in    = AW'(b);
    stride_in  = AW'(st);
    num_win_in = CNT_W'(n);
    start      = 1'b1;
    for (int w = 0; w < n; w++) exp_q.push_back(model_window(b % SIZE, st % SIZE, w, w == n - 1));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int rand_ready);
    int budget;
    budget = 0;
    while ((busy || exp_q.size() != 0) && budget < 500) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      budget++;
    end
    check("drain_busy", EW'(busy), EW'(0));
    check("drain_queue", EW'(exp_q.size()), EW'(0));
  endtask

  task automatic check_all_zero(input string name);
    check(name, EW'({out_valid, busy, done, win_idx, hit_mask, sel_map, gen_nums}), EW'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_in = '0; stride_in = '0; num_win_in = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst = 1'b0;
    @(posedge clk); #1;

    // two windows, base 4 stride 8
    out_ready = 1'b1;
    issue_start(4, 8, 2);
    check("w0_gen", EW'(gen_nums), EW'(32'hBA987654));
    check("w0_hit", EW'(hit_mask), EW'(16'h0FF0));
    check("w0_sel4", EW'(sel_map[4*KW +: KW]), EW'(0));
    check("w0_sel11", EW'(sel_map[11*KW +: KW]), EW'(7));
    @(posedge clk); #1;
    check("w1_gen", EW'(gen_nums), EW'(32'h3210FEDC));
    check("w1_hit", EW'(hit_mask), EW'(16'hF00F));
    check("w1_sel0", EW'(sel_map[0 +: KW]), EW'(4));
    check("w1_idx", EW'(win_idx), EW'(1));
    @(posedge clk); #1;
    check("done_high", EW'({done, busy, out_valid}), EW'(3'b110));
    @(posedge clk); #1;
    check("back_idle", EW'({done, busy, out_valid}), EW'(3'b000));

    // wrap-around window
    issue_start(15, 1, 1);
    check("wrap_hit", EW'(hit_mask), EW'(16'h807F));
    check("wrap_sel15", EW'(sel_map[15*KW +: KW]), EW'(0));
    check("wrap_sel0", EW'(sel_map[0 +: KW]), EW'(1));
    check("wrap_sel6", EW'(sel_map[6*KW +: KW]), EW'(7));
    wait_idle(0);

    // backpressure on window 0
    out_ready = 1'b0;
    issue_start(4, 8, 2);
    for (int c = 0; c < 3; c++) begin
      check("stall_idx", EW'({out_valid, win_idx}), EW'({1'b1, 8'd0}));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("after_stall_idx", EW'({out_valid, win_idx}), EW'({1'b1, 8'd1}));
    wait_idle(0);

    // start pulses during RUN must not disturb the sequence
    out_ready = 1'b0;
    issue_start(2, 3, 3);
    base_in = 4'd9; stride_in = 4'd5; num_win_in = 8'd7; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(1);

    // start with zero windows is ignored in IDLE
    issue_start(5, 2, 0);
    for (int c = 0; c < 3; c++) begin
      check("zero_start_idle", EW'({busy, out_valid}), EW'(0));
      @(posedge clk); #1;
    end

    // reset in the middle of a 4-window run
    out_ready = 1'b1;
    issue_start(1, 2, 4);
    @(posedge clk); #1;
    check("mid_idx", EW'({out_valid, win_idx}), EW'({1'b1, 8'd1}));
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("mid_reset_outputs");
    rst = 1'b0;
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_idle", EW'({busy, out_valid}), EW'(0));

    // randomized sequences with random backpressure
    for (int t = 0; t < 25; t++) begin
      issue_start($urandom_range(0, SIZE-1), $urandom_range(0, SIZE-1), $urandom_range(1, 6));
      wait_idle(1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
